// File: rtl/iddmm_res_collect_pkg.sv
// Shared IDDMM (iterative digit Montgomery multiplier) types and default sizes.
package iddmm_res_collect_pkg;

  // Default result word width and words per result frame.
  localparam int IDDMM_K = 128;
  localparam int IDDMM_N = 32;

  // Result collector states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } res_state_e;

  // Even parity over a result word, for optional protection of stored words.
  function automatic logic word_parity(input logic [IDDMM_K-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/iddmm_res_collect_buf.sv
// N x K result storage: one synchronous write port, one combinational read port.
// Contents are intentionally not reset; only words written in the current
// frame are ever read back.
module iddmm_res_buf #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [K-1:0]      wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [K-1:0]      rdata_o
);

  logic [K-1:0] mem_q [N];

  // Store the incoming word at the write index.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/iddmm_res_collect.sv
// Collects one N-word Montgomery result frame from the iteration engine and
// replays it to a valid/ready consumer, flagging length and overflow errors.
module iddmm_res_collect
  import iddmm_res_collect_pkg::*;
#(
  parameter int K      = IDDMM_K,
  parameter int N      = IDDMM_N,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              task_grant,
  input  logic              task_end,
  input  logic [K-1:0]      task_res,
  output logic              busy,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [K-1:0]      m_data,
  output logic [ADDR_W-1:0] m_idx,
  output logic              m_last,
  output logic              err_len,
  output logic              err_ovf,
  input  logic              err_clr
);

  // Word count needs one extra bit so that "N words written" is representable.
  localparam logic [ADDR_W:0]   N_CNT    = (ADDR_W+1)'(N);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N-1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  res_state_e        state_q;
  logic [ADDR_W:0]   wr_cnt_q;
  logic [ADDR_W:0]   wr_cnt_d;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic              err_len_q;
  logic              err_ovf_q;

  logic              capture_s;
  logic              frame_done_s;
  logic              len_err_s;
  logic              ovf_s;
  logic              drain_s;
  logic              hs_s;
  logic [K-1:0]      rd_data_s;

  // Classify this cycle's upstream activity against the current word count.
  always_comb begin
    drain_s      = (state_q == ST_DRAIN);
    capture_s    = task_grant && !drain_s;
    wr_cnt_d     = wr_cnt_q + CNT_ONE;
    frame_done_s = capture_s && task_end && (wr_cnt_d == N_CNT);
    // Wrong end position, or the frame filled up without an end marker.
    len_err_s    = capture_s && ((task_end && (wr_cnt_d != N_CNT)) ||
                                 (!task_end && (wr_cnt_d == N_CNT)));
    ovf_s        = task_grant && drain_s;
    hs_s         = drain_s && m_ready;
  end

  // Frame FSM with write count and read pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_cnt_q <= {(ADDR_W+1){1'b0}};
      rd_ptr_q <= {ADDR_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE, ST_CAPTURE: begin
          if (len_err_s) begin
            // Discard the partial frame.
            state_q  <= ST_IDLE;
            wr_cnt_q <= {(ADDR_W+1){1'b0}};
          end else if (frame_done_s) begin
            state_q  <= ST_DRAIN;
            wr_cnt_q <= {(ADDR_W+1){1'b0}};
            rd_ptr_q <= {ADDR_W{1'b0}};
          end else if (capture_s) begin
            state_q  <= ST_CAPTURE;
            wr_cnt_q <= wr_cnt_d;
          end else begin
            state_q  <= state_q;
            wr_cnt_q <= wr_cnt_q;
          end
        end
        ST_DRAIN: begin
          if (hs_s) begin
            if (rd_ptr_q == LAST_IDX) begin
              state_q  <= ST_IDLE;
              rd_ptr_q <= {ADDR_W{1'b0}};
            end else begin
              rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
          end else begin
            rd_ptr_q <= rd_ptr_q;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          wr_cnt_q <= {(ADDR_W+1){1'b0}};
          rd_ptr_q <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  // Sticky error flags; a new error event wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_len_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      if (len_err_s) begin
        err_len_q <= 1'b1;
      end else if (err_clr) begin
        err_len_q <= 1'b0;
      end else begin
        err_len_q <= err_len_q;
      end
      if (ovf_s) begin
        err_ovf_q <= 1'b1;
      end else if (err_clr) begin
        err_ovf_q <= 1'b0;
      end else begin
        err_ovf_q <= err_ovf_q;
      end
    end
  end

  iddmm_res_buf #(
    .K      (K),
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .we_i    (capture_s),
    .waddr_i (wr_cnt_q[ADDR_W-1:0]),
    .wdata_i (task_res),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data_s)
  );

  // Outputs decode only registered state, so they are glitch-free and held
  // stable across stalls (rd_ptr only moves on a handshake).
  assign busy    = (state_q != ST_IDLE);
  assign m_valid = drain_s;
  assign m_idx   = drain_s ? rd_ptr_q : {ADDR_W{1'b0}};
  assign m_last  = drain_s && (rd_ptr_q == LAST_IDX);
  assign m_data  = drain_s ? rd_data_s : {K{1'b0}};
  assign err_len = err_len_q;
  assign err_ovf = err_ovf_q;

endmodule

// File: tb/tb_iddmm_res_collect.sv
// Self-checking bench for iddmm_res_collect (K=128, N=4).
module tb_iddmm_res_collect;

  localparam int K  = 128;
  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          task_grant;
  logic          task_end;
  logic [K-1:0]  task_res;
  logic          busy;
  logic          m_valid;
  logic          m_ready;
  logic [K-1:0]  m_data;
  logic [AW-1:0] m_idx;
  logic          m_last;
  logic          err_len;
  logic          err_ovf;
  logic          err_clr;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int hs;
  int cyc;

  // Reference model: words of every accepted frame, in delivery order.
  logic [K-1:0] exp_q [$];

  iddmm_res_collect #(.K(K), .N(N), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .task_grant (task_grant),
    .task_end   (task_end),
    .task_res   (task_res),
    .busy       (busy),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_idx      (m_idx),
    .m_last     (m_last),
    .err_len    (err_len),
    .err_ovf    (err_ovf),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A frame is delivered only if exactly N words arrive with the end marker on the last.
  function automatic bit frame_ok(input int nwords, input int end_pos);
    return (nwords == N) && (end_pos == N);
  endfunction

  // Present nwords grant cycles; end marker on word end_pos (1-based, 0 = none).
  task automatic send(input int nwords, input int end_pos, input bit rnd, input bit clr_on_end);
    logic [K-1:0] words [$];
    logic [K-1:0] w;
    for (int i = 0; i < nwords; i++) begin
      if (rnd) w = {$urandom(), $urandom(), $urandom(), $urandom()};
      else     w = K'(16 + i);
      words.push_back(w);
      task_grant = 1'b1;
      task_res   = w;
      task_end   = (i + 1 == end_pos);
      err_clr    = clr_on_end && (i + 1 == end_pos);
      @(posedge clk); #1;
      if (i + 1 < nwords) begin
        chk("cap_busy", K'(busy), K'(1));
        chk("cap_no_valid", K'(m_valid), K'(0));
      end
    end
    task_grant = 1'b0;
    task_end   = 1'b0;
    err_clr    = 1'b0;
    if (frame_ok(nwords, end_pos)) begin
      foreach (words[j]) exp_q.push_back(words[j]);
    end
  endtask

  // Consume expected words; mode 0 ready=1, 1 pattern 1,0,0, 2 random.
  task automatic drain(input int mode, input int inject_at, output int nhs, output int ncyc);
    int idx;
    idx  = 0;
    nhs  = 0;
    ncyc = 0;
    while (exp_q.size() > 0 && ncyc < 200) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (ncyc % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      task_grant = (ncyc == inject_at);
      task_res   = {$urandom(), $urandom(), $urandom(), $urandom()};
      chk("m_valid", K'(m_valid), K'(1));
      chk("m_data", m_data, exp_q[0]);
      chk("m_idx", K'(m_idx), K'(idx));
      chk("m_last", K'(m_last), K'(idx == N - 1));
      if (m_ready) begin
        void'(exp_q.pop_front());
        idx++;
        nhs++;
      end
      @(posedge clk); #1;
      ncyc++;
    end
    task_grant = 1'b0;
    m_ready    = 1'b1;
    chk("drain_done", K'(exp_q.size()), K'(0));
    chk("post_busy", K'(busy), K'(0));
    chk("post_valid", K'(m_valid), K'(0));
    chk("post_idx", K'(m_idx), K'(0));
    chk("post_last", K'(m_last), K'(0));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst        = 1'b1;
    task_grant = 1'b0;
    task_end   = 1'b0;
    task_res   = '0;
    m_ready    = 1'b1;
    err_clr    = 1'b0;
    repeat (3) tick();
    chk("rst_busy", K'(busy), K'(0));
    chk("rst_valid", K'(m_valid), K'(0));
    chk("rst_last", K'(m_last), K'(0));
    chk("rst_idx", K'(m_idx), K'(0));
    chk("rst_data", m_data, K'(0));
    chk("rst_err_len", K'(err_len), K'(0));
    chk("rst_err_ovf", K'(err_ovf), K'(0));
    rst = 1'b0;
    tick();

    // Basic frame 0x10..0x13, ready held high: N-cycle drain.
    send(N, N, 1'b0, 1'b0);
    drain(0, -1, hs, cyc);
    chk("basic_hs", K'(hs), K'(N));
    chk("basic_cycles", K'(cyc), K'(N));
    chk("basic_err_len", K'(err_len), K'(0));

    // Same frame with stalls.
    tick();
    send(N, N, 1'b0, 1'b0);
    drain(1, -1, hs, cyc);
    chk("stall_hs", K'(hs), K'(N));

    // Early end marker on the 3rd word.
    tick();
    send(3, 3, 1'b0, 1'b0);
    chk("early_err_len", K'(err_len), K'(1));
    chk("early_busy", K'(busy), K'(0));
    chk("early_valid", K'(m_valid), K'(0));
    tick();
    chk("early_valid2", K'(m_valid), K'(0));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err_len", K'(err_len), K'(0));

    // N words without end marker, then a single word with end in IDLE.
    send(N, 0, 1'b1, 1'b0);
    chk("noend_err_len", K'(err_len), K'(1));
    chk("noend_busy", K'(busy), K'(0));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    send(1, 1, 1'b1, 1'b0);
    chk("one_err_len", K'(err_len), K'(1));
    chk("one_valid", K'(m_valid), K'(0));

    // Error set coinciding with clear: set wins.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    send(3, 3, 1'b1, 1'b1);
    chk("set_over_clr", K'(err_len), K'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Grant during drain: overflow flagged, data untouched.
    send(N, N, 1'b0, 1'b0);
    drain(0, 1, hs, cyc);
    chk("ovf_flag", K'(err_ovf), K'(1));
    chk("ovf_hs", K'(hs), K'(N));
    chk("ovf_len_clean", K'(err_len), K'(0));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_clr", K'(err_ovf), K'(0));

    // Reset mid-capture after 2 words.
    send(2, 0, 1'b1, 1'b0);
    chk("mid_busy", K'(busy), K'(1));
    rst = 1'b1;
    #2;
    chk("arst_busy", K'(busy), K'(0));
    chk("arst_valid", K'(m_valid), K'(0));
    chk("arst_data", m_data, K'(0));
    chk("arst_err_len", K'(err_len), K'(0));
    chk("arst_err_ovf", K'(err_ovf), K'(0));
    tick();
    rst = 1'b0;
    tick();
    send(N, N, 1'b1, 1'b0);
    drain(2, -1, hs, cyc);
    chk("after_rst_hs", K'(hs), K'(N));

    // Back-to-back random frames, 1 idle cycle between them.
    for (int f = 0; f < 4; f++) begin
      tick();
      send(N, N, 1'b1, 1'b0);
      drain((f % 2 == 0) ? 0 : 2, -1, hs, cyc);
      chk("b2b_hs", K'(hs), K'(N));
    end
    chk("b2b_err_len", K'(err_len), K'(0));
    chk("b2b_err_ovf", K'(err_ovf), K'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
